sync_event_filter: RTL and testbench
====================================

# sync_event_filter

Single-clock glitch filter and transition-event reporter for the destination clock domain of a CDC path. Consumes the already-synchronized level from the two-flop synchronizer, requires each level change to hold for a programmable number of cycles, and reports accepted transitions to a downstream consumer over a valid/ready handshake.

## Interface
- STABLE_CYCLES, 3: consecutive samples at the new level required to accept a change; legal range 1..255.
- CNT_W, 8: width of the pending-event count.
- clk  input  1  destination-domain clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sync_in  input  1  synchronized level from the synchronizer output stage.
- clr  input  1  synchronous clear of pending count and overflow; filter state is kept.
- filt_out  output  1  filtered level.
- glitch  output  1  one-cycle pulse: a change was rejected before qualifying.
- evt_valid  output  1  at least one accepted transition is pending.
- evt_ready  input  1  consumer accepts the pending report.
- evt_count  output  CNT_W  accepted transitions since the last handshake.
- evt_level  output  1  filt_out value after the most recent accepted transition.
- overflow  output  1  sticky: pending count saturated.

## Operation
- FSM states: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO; reset state STABLE_LO.
- STABLE_LO: sync_in=1 -> QUAL_HI, stability counter = 1. STABLE_HI: sync_in=0 -> QUAL_LO, counter = 1 (symmetric).
- QUAL_HI: sync_in=1 -> counter+1; on the sample where the counter reaches STABLE_CYCLES -> STABLE_HI, filt_out<=1, accept event. sync_in=0 -> STABLE_LO, glitch pulse, counter cleared.
- STABLE_CYCLES=1: the first differing sample is accepted directly; the QUAL states are never held.
- Accepted event: pending count +1, evt_level <= new filt_out.
- Handshake: evt_valid = (pending != 0). On evt_valid && evt_ready, pending is consumed; evt_count is the value presented in that cycle.
- Event in the same cycle as a handshake: pending becomes 1, evt_valid stays high.
- Saturation: pending holds at 2^CNT_W-1; further events set overflow; evt_level still updates.
- clr: pending<=0, overflow<=0; a simultaneous accepted event wins (pending=1). Higher priority than a simultaneous handshake.
- evt_count/evt_level stay stable while evt_valid && !evt_ready, except for increments from new events.

## Timing
- Reset values: filt_out 0, glitch 0, evt_valid 0, evt_count 0, evt_level 0, overflow 0, stability counter 0.
- All outputs registered; no combinational path from any input to any output.
- Latency: change first sampled at edge k -> filt_out and evt_valid update at edge k+STABLE_CYCLES-1.
- glitch asserts for exactly one cycle, at the edge that samples the reverting level.
- Reset asserted mid-qualification or mid-handshake: immediate return to reset values. The first post-reset sample with sync_in=1 starts qualification normally.
- After reset deassertion, sync_in=1 is treated as a change from 0.

## Structure
- Package sync_event_pkg: FSM state enum, default STABLE_CYCLES/CNT_W constants, stability-counter width (8 bits).
- Sub-module sync_stability_counter: load-to-1, increment, clear, and terminal flag at STABLE_CYCLES.
- Top level holds the FSM, pending counter, overflow, and handshake registers.

## Test plan
- STABLE_CYCLES=3: sync_in 0->1 held 5 cycles, first sampled at edge 10 -> filt_out=1 and evt_valid=1 at edge 12; evt_count=1, evt_level=1.
- sync_in high for 2 samples, then low -> glitch pulse on the third edge; filt_out stays 0; no event.
- Three accepted transitions with evt_ready=0 -> evt_count=3, evt_level=1. Assert evt_ready for one cycle -> evt_valid=0 next edge.
- Accepted event coincident with a handshake -> evt_valid stays 1, evt_count=1.
- CNT_W=2, five accepted transitions without ready -> evt_count=3, overflow=1. Pulse clr -> evt_count=0, overflow=0, filt_out unchanged.
- rst_n low during QUAL_HI with evt_valid=1 -> all outputs 0 immediately. With sync_in held 1 after release, filt_out=1 at STABLE_CYCLES-1 edges after the first post-reset sample.

Source files
------------

// File: rtl/sync_event_pkg.sv
// Shared types and defaults for the synchronized-level glitch filter.
package sync_event_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        QUAL_HI,
        STABLE_HI,
        QUAL_LO
    } filt_state_e;

    localparam int unsigned DEF_STABLE_CYCLES = 3;
    localparam int unsigned DEF_CNT_W         = 8;
    localparam int unsigned STAB_CNT_W        = 8;

endpackage

// File: rtl/sync_stability_counter.sv
// Counts consecutive samples at a candidate level; flags when the next sample qualifies it.
module sync_stability_counter
    import sync_event_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    input  logic clr,
    output logic at_term
);

    localparam logic [STAB_CNT_W:0] TERM = (STAB_CNT_W + 1)'(STABLE_CYCLES);
    localparam logic [STAB_CNT_W:0] ONE  = (STAB_CNT_W + 1)'(1);

    logic [STAB_CNT_W-1:0] cnt;

    // Looks one sample ahead so the FSM accepts on the sample that reaches the threshold.
    assign at_term = ({1'b0, cnt} + ONE) >= TERM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= STAB_CNT_W'(1);
        end else if (inc) begin
            cnt <= cnt + STAB_CNT_W'(1);
        end
    end

endmodule

// File: rtl/sync_event_filter.sv
// Glitch filter on a synchronized level with a valid/ready report of accepted transitions.
module sync_event_filter
    import sync_event_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_in,
    input  logic             clr,
    output logic             filt_out,
    output logic             glitch,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic             evt_level,
    output logic             overflow
);

    localparam bit DIRECT = (STABLE_CYCLES == 1);

    filt_state_e      state;
    logic             at_term;
    logic             cnt_load, cnt_inc, cnt_clr;
    logic             accept, reject;
    logic             handshake;
    logic [CNT_W-1:0] pending_nxt;
    logic             overflow_nxt;

    sync_stability_counter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_stab_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_load),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .at_term(at_term)
    );

    always_comb begin
        accept   = 1'b0;
        reject   = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        case (state)
            STABLE_LO, STABLE_HI: begin
                if (sync_in != filt_out) begin
                    if (DIRECT) accept   = 1'b1;
                    else        cnt_load = 1'b1;
                end
            end
            QUAL_HI, QUAL_LO: begin
                if (sync_in != filt_out) begin
                    accept  = at_term;
                    cnt_inc = !at_term;
                    cnt_clr = at_term;
                end else begin
                    reject  = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= STABLE_LO;
            filt_out <= 1'b0;
            glitch   <= 1'b0;
        end else begin
            glitch <= reject;
            if (accept) begin
                filt_out <= sync_in;
                state    <= sync_in ? STABLE_HI : STABLE_LO;
            end else if (reject) begin
                state    <= filt_out ? STABLE_HI : STABLE_LO;
            end else if (cnt_load) begin
                state    <= sync_in ? QUAL_HI : QUAL_LO;
            end
        end
    end

    assign handshake = evt_valid && evt_ready;

    // clr outranks a handshake; an event in the same cycle as either restarts the count at 1.
    always_comb begin
        pending_nxt  = evt_count;
        overflow_nxt = overflow;
        if (clr) begin
            pending_nxt  = {{(CNT_W-1){1'b0}}, accept};
            overflow_nxt = 1'b0;
        end else if (handshake) begin
            pending_nxt  = {{(CNT_W-1){1'b0}}, accept};
        end else if (accept) begin
            if (evt_count == '1) overflow_nxt = 1'b1;
            else                 pending_nxt  = evt_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_count <= '0;
            evt_valid <= 1'b0;
            evt_level <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            evt_count <= pending_nxt;
            evt_valid <= |pending_nxt;
            overflow  <= overflow_nxt;
            if (accept) evt_level <= sync_in;
        end
    end

endmodule

// File: tb/tb_sync_event_filter.sv
// Self-checking bench: directed vector table, hand sequences and a randomized model comparison.
module tb_sync_event_filter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync_in = 1'b0;
    logic       clr = 1'b0;
    logic       evt_ready = 1'b0;

    logic       a_filt, a_glitch, a_valid, a_level, a_ovf;
    logic [7:0] a_count;
    logic       b_filt, b_glitch, b_valid, b_level, b_ovf;
    logic [1:0] b_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_event_filter #(.STABLE_CYCLES(3), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .clr(clr),
        .filt_out(a_filt), .glitch(a_glitch), .evt_valid(a_valid),
        .evt_ready(evt_ready), .evt_count(a_count), .evt_level(a_level),
        .overflow(a_ovf)
    );

    sync_event_filter #(.STABLE_CYCLES(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .clr(clr),
        .filt_out(b_filt), .glitch(b_glitch), .evt_valid(b_valid),
        .evt_ready(evt_ready), .evt_count(b_count), .evt_level(b_level),
        .overflow(b_ovf)
    );

    // Reference model: a change is accepted once the run of samples differing
    // from the filtered level reaches the threshold; an early end is a glitch.
    int m_thr[2] = '{3, 1};
    int m_max[2] = '{255, 3};
    int m_filt[2], m_run[2], m_pend[2], m_ovf[2], m_lvl[2], m_gl[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_filt[i] = 0; m_run[i] = 0; m_pend[i] = 0;
            m_ovf[i]  = 0; m_lvl[i] = 0; m_gl[i]   = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit hs;
            bit acc;
            hs  = (m_pend[i] != 0) && evt_ready;
            acc = 1'b0;
            m_gl[i] = 0;
            if (int'(sync_in) != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] >= m_thr[i]) begin
                    acc = 1'b1;
                    m_filt[i] = int'(sync_in);
                    m_lvl[i]  = int'(sync_in);
                    m_run[i]  = 0;
                end
            end else begin
                m_gl[i]  = (m_run[i] > 0) ? 1 : 0;
                m_run[i] = 0;
            end
            if (clr) begin
                m_pend[i] = acc ? 1 : 0;
                m_ovf[i]  = 0;
            end else if (hs) begin
                m_pend[i] = acc ? 1 : 0;
            end else if (acc) begin
                if (m_pend[i] == m_max[i]) m_ovf[i] = 1;
                else                       m_pend[i]++;
            end
        end
    endtask

    function automatic logic [12:0] pack(input logic f, input logic g, input logic v,
                                         input logic l, input logic o, input logic [7:0] c);
        return {f, g, v, l, o, c};
    endfunction

    function automatic logic [12:0] model_vec(input int i);
        return pack(m_filt[i][0], m_gl[i][0], m_pend[i] != 0, m_lvl[i][0], m_ovf[i][0],
                    m_pend[i][7:0]);
    endfunction

    function automatic logic [12:0] a_vec();
        return pack(a_filt, a_glitch, a_valid, a_level, a_ovf, a_count);
    endfunction

    function automatic logic [12:0] b_vec();
        return pack(b_filt, b_glitch, b_valid, b_level, b_ovf, {6'd0, b_count});
    endfunction

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got {f,g,v,l,o,cnt}=%b_%h expected %b_%h",
                     nm, $time, act[12:8], act[7:0], exp[12:8], exp[7:0]);
        end
    endtask

    task automatic step(input logic s, input logic c, input logic r);
        sync_in   = s;
        clr       = c;
        evt_ready = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic async_reset(input string nm);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({nm, "_a"}, a_vec(), '0);
        chk({nm, "_b"}, b_vec(), '0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       s, c, r;
        logic       f, g, v, l, o;
        logic [7:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic c, input logic r,
                                input logic f, input logic g, input logic v,
                                input logic l, input logic o, input logic [7:0] cnt);
        vec_t t;
        t.s = s; t.c = c; t.r = r; t.f = f; t.g = g; t.v = v; t.l = l; t.o = o; t.cnt = cnt;
        return t;
    endfunction

    vec_t tbl[19];

    initial begin
        logic s_r;

        //           s  c  r  f  g  v  l  o  cnt
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 1, 0, 1, 1, 0, 1);
        tbl[4]  = mk(1, 0, 0, 1, 0, 1, 1, 0, 1);
        tbl[5]  = mk(0, 0, 0, 1, 0, 1, 1, 0, 1);
        tbl[6]  = mk(1, 0, 0, 1, 1, 1, 1, 0, 1);
        tbl[7]  = mk(1, 0, 0, 1, 0, 1, 1, 0, 1);
        tbl[8]  = mk(0, 0, 1, 1, 0, 0, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 0);
        tbl[10] = mk(0, 0, 1, 0, 0, 1, 0, 0, 1);
        tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 0, 0, 1, 0, 1, 1, 0, 1);
        tbl[15] = mk(0, 0, 0, 1, 0, 1, 1, 0, 1);
        tbl[16] = mk(0, 0, 0, 1, 0, 1, 1, 0, 1);
        tbl[17] = mk(0, 0, 1, 0, 0, 1, 0, 0, 1);
        tbl[18] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);

        #12;
        model_reset();
        chk("reset_a", a_vec(), '0);
        chk("reset_b", b_vec(), '0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].s, tbl[i].c, tbl[i].r);
            chk($sformatf("vec%0d", i), a_vec(),
                pack(tbl[i].f, tbl[i].g, tbl[i].v, tbl[i].l, tbl[i].o, tbl[i].cnt));
        end

        // Three accepted transitions with no consumer, then a single-cycle ready.
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 3; k++) step(t % 2 == 0, 1'b0, 1'b0);
        end
        chk("three_pending", a_vec(), pack(1, 0, 1, 1, 0, 8'd3));
        step(1'b1, 1'b0, 1'b1);
        chk("three_consumed", a_vec(), pack(1, 0, 0, 1, 0, 8'd0));

        // Reset while qualifying a rising edge with a report pending.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0);
        chk("pre_reset_pend", a_vec(), pack(0, 0, 1, 0, 0, 8'd1));
        step(1'b1, 1'b0, 1'b0);
        async_reset("mid_qual_reset");
        step(1'b1, 1'b0, 1'b0);
        chk("post_rst_k", a_vec(), '0);
        step(1'b1, 1'b0, 1'b0);
        chk("post_rst_k1", a_vec(), '0);
        step(1'b1, 1'b0, 1'b0);
        chk("post_rst_k2", a_vec(), pack(1, 0, 1, 1, 0, 8'd1));

        // Narrow pending count on the single-sample instance: saturation then clr.
        async_reset("sat_reset");
        step(1'b1, 1'b0, 1'b0);
        chk("direct_accept", b_vec(), pack(1, 0, 1, 1, 0, 8'd1));
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("sat_at_max", b_vec(), pack(1, 0, 1, 1, 0, 8'd3));
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("sat_overflow", b_vec(), pack(1, 0, 1, 1, 1, 8'd3));
        step(1'b1, 1'b1, 1'b0);
        chk("sat_clr", b_vec(), pack(1, 0, 0, 1, 0, 8'd0));

        async_reset("rand_reset");
        s_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 4) s_r = ~s_r;
            step(s_r, $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0);
            chk("rand_a", a_vec(), model_vec(0));
            chk("rand_b", b_vec(), model_vec(1));
            if (i % 500 == 499) async_reset("rand_mid_reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
